// File: rtl/order_tx.sv
// order_tx: FIFO-buffered 128-bit orders sent as two-beat 64-bit ready/valid packets; ORDER_TX_SEQNUM_EN stamps a sequence number into beat 0
module order_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ord_valid,
  input  logic                      ord_sym_vld,
  input  logic [127:0]              ord_data,
  output logic [63:0]               tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_sop,
  output logic                      tx_eop,
  output logic                      fifo_full,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t state_q, state_d;
  logic [127:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic push, pop, full;
  logic [127:0] head;
  logic [63:0] beat0;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign head = mem_q[rd_ptr_q];
  always_comb begin
    push = ord_valid && ord_sym_vld && !full;
    pop = (state_q == BEAT1) && tx_ready;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_d = (ord_valid && ord_sym_vld && full && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_q != '0) state_d = BEAT0;
      BEAT0:   if (tx_ready) state_d = BEAT1;
      BEAT1:   if (tx_ready) state_d = (cnt_d != '0) ? BEAT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ord_data;
  end
`ifdef ORDER_TX_SEQNUM_EN
  logic [15:0] seq_q, seq_d;
  assign seq_d = pop ? seq_q + 16'd1 : seq_q;
  always_ff @(posedge clk) begin
    if (reset) seq_q <= '0;
    else seq_q <= seq_d;
  end
  assign beat0 = {seq_q, head[111:64]};
`else
  assign beat0 = head[127:64];
`endif
  assign tx_valid  = state_q != IDLE;
  assign tx_sop    = state_q == BEAT0;
  assign tx_eop    = state_q == BEAT1;
  assign tx_data   = (state_q == BEAT0) ? beat0 : (state_q == BEAT1) ? head[63:0] : '0;
  assign fifo_full = full;
  assign drop_cnt  = drop_q;
endmodule
